// File: rtl/keypad_scan.sv
// Row-scanned 4x3 keypad reader with whole-frame debounce.
// KEYPAD_MULTIKEY_EN: pass the full multi-hot key map instead of only its lowest set key.
module keypad_scan #(
    parameter int SCAN_DIV     = 1000,
    parameter int DEBOUNCE_CNT = 4
) (
    input  logic        clk,
    input  logic        rst_x,
    input  logic [2:0]  col_in,
    output logic [3:0]  row_out,
    output logic [11:0] keypad_out,
    output logic        key_valid,
    output logic        frame_done
);

    localparam logic [15:0] TICK_LAST = 16'(SCAN_DIV - 1);
    localparam logic [3:0]  DB_MAX    = 4'(DEBOUNCE_CNT);
    localparam logic [3:0]  DB_PRE    = 4'(DEBOUNCE_CNT - 1);

    logic [2:0]  col_s1;
    logic [2:0]  col_s2;
    logic [15:0] tick;
    logic [1:0]  row;
    logic [11:0] raw_frame;
    logic [11:0] prev_frame;
    logic [3:0]  stable_cnt;
    logic        upd_pend;
    logic [11:0] out_map;
    logic        sample;

    assign sample  = (tick == TICK_LAST);
    assign row_out = ~(4'b0001 << row);

    // Columns idle high; synchronizer resets to the released level.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            col_s1 <= 3'b111;
            col_s2 <= 3'b111;
        end else begin
            col_s1 <= col_in;
            col_s2 <= col_s1;
        end
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            tick       <= '0;
            row        <= '0;
            raw_frame  <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= sample && (row == 2'd3);
            if (sample) begin
                tick <= '0;
                row  <= row + 2'd1;
                for (int r = 0; r < 4; r++) begin
                    if (row == 2'(r)) begin
                        raw_frame[r*3 +: 3] <= ~col_s2;
                    end
                end
            end else begin
                tick <= tick + 16'd1;
            end
        end
    end

    // Frame comparison runs in the frame_done cycle, so raw_frame already holds row 3.
    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            prev_frame <= '0;
            stable_cnt <= '0;
            upd_pend   <= 1'b0;
        end else begin
            upd_pend <= 1'b0;
            if (frame_done) begin
                if (raw_frame == prev_frame) begin
                    if (stable_cnt != DB_MAX) begin
                        stable_cnt <= stable_cnt + 4'd1;
                    end
                    upd_pend <= (stable_cnt == DB_PRE);
                end else begin
                    stable_cnt <= '0;
                    prev_frame <= raw_frame;
                end
            end
        end
    end

    always_comb begin
        out_map = '0;
`ifdef KEYPAD_MULTIKEY_EN
        out_map = prev_frame;
`else
        // Isolate the lowest set bit so only one note is ever requested.
        out_map = prev_frame & (~prev_frame + 12'd1);
`endif
    end

    always_ff @(posedge clk or negedge rst_x) begin
        if (!rst_x) begin
            keypad_out <= '0;
            key_valid  <= 1'b0;
        end else if (upd_pend) begin
            keypad_out <= out_map;
            key_valid  <= |out_map;
        end
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a keypad matrix model drives col_in, a frame-level model predicts keypad_out.
module tb_keypad_scan;

    localparam int SCAN_DIV = 4;
    localparam int DB       = 2;

    logic        clk = 1'b0;
    logic        rst_x = 1'b0;
    logic [2:0]  col_in;
    logic [3:0]  row_out;
    logic [11:0] keypad_out;
    logic        key_valid;
    logic        frame_done;
    logic [11:0] pressed = '0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [11:0] hist[$];
    logic [11:0] exp_q[$];
    logic [11:0] cur_keys;
    logic [11:0] exp_cur;
    logic [3:0]  row_tbl [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    keypad_scan #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_CNT(DB)) dut (
        .clk        (clk),
        .rst_x      (rst_x),
        .col_in     (col_in),
        .row_out    (row_out),
        .keypad_out (keypad_out),
        .key_valid  (key_valid),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // A pressed key shorts its column to any row driven low.
    always_comb begin
        col_in = 3'b111;
        for (int r = 0; r < 4; r++) begin
            if (!row_out[r]) col_in = col_in & ~pressed[r*3 +: 3];
        end
    end

    task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [11:0] select_out(input logic [11:0] m);
        logic [11:0] res;
        logic        found;
        res   = '0;
        found = 1'b0;
`ifdef KEYPAD_MULTIKEY_EN
        res = m;
`else
        for (int i = 0; i < 12; i++) begin
            if (m[i] && !found) begin
                res[i] = 1'b1;
                found  = 1'b1;
            end
        end
`endif
        return res;
    endfunction

    task automatic model_reset();
        hist.delete();
        hist.push_back(12'h000);
        exp_q.delete();
        exp_cur  = '0;
        cur_keys = pressed;
    endtask

    // Output follows a frame once DB+1 consecutive frames (reset counts as one empty frame) agree.
    task automatic model_frame(input logic [11:0] keys);
        logic same;
        hist.push_back(keys);
        if (hist.size() > DB + 1) void'(hist.pop_front());
        same = (hist.size() == DB + 1);
        foreach (hist[i]) if (hist[i] != keys) same = 1'b0;
        exp_q.push_back(same ? select_out(keys) : exp_cur);
    endtask

    task automatic do_frame(input logic [11:0] next_keys, input string tag);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!frame_done && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_frame_done"}, {11'b0, frame_done}, 12'h001);
        model_frame(cur_keys);
        check({tag, "_hold"}, keypad_out, exp_cur);
        pressed  = next_keys;
        cur_keys = next_keys;
        @(negedge clk);
        check({tag, "_pulse_end"}, {11'b0, frame_done}, 12'h000);
        check({tag, "_latency"}, keypad_out, exp_cur);
        @(negedge clk);
        exp_cur = exp_q.pop_front();
        check({tag, "_keypad"}, keypad_out, exp_cur);
        check({tag, "_valid"}, {11'b0, key_valid}, {11'b0, |exp_cur});
    endtask

    // Release reset on a negedge and follow the first frame's row rotation edge by edge.
    task automatic release_and_rotate(input string tag);
        @(negedge clk);
        rst_x = 1'b1;
        model_reset();
        check({tag, "_row_n0"}, {8'b0, row_out}, {8'b0, row_tbl[0]});
        for (int n = 1; n < 16; n++) begin
            @(negedge clk);
            check({tag, "_row"}, {8'b0, row_out}, {8'b0, row_tbl[(n / SCAN_DIV) % 4]});
            check({tag, "_no_done"}, {11'b0, frame_done}, 12'h000);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_row"}, {8'b0, row_out}, 12'h00E);
        check({tag, "_keypad"}, keypad_out, 12'h000);
        check({tag, "_valid"}, {11'b0, key_valid}, 12'h000);
        check({tag, "_done"}, {11'b0, frame_done}, 12'h000);
    endtask

    initial begin
        logic [11:0] k;
        rst_x   = 1'b0;
        pressed = '0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        release_and_rotate("rot");

        // idle frames, then a single key in row 2 column 1
        do_frame(12'h000, "idle0");
        do_frame(12'h080, "idle1");
        for (int i = 0; i < 4; i++) do_frame(12'h080, "press");
        for (int i = 0; i < 4; i++) do_frame(12'h000, "release");

        // one-frame press must be filtered out
        do_frame(12'h080, "glitch_set");
        for (int i = 0; i < 4; i++) do_frame(12'h000, "glitch");

        // two keys at once
        do_frame(12'h204, "dual_set");
        for (int i = 0; i < 4; i++) do_frame(12'h204, "dual");

        // randomized frame sequence with frequent holds so patterns settle
        k = 12'h204;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                k = ($urandom_range(0, 3) == 0) ? 12'h000 : (12'($urandom) & 12'($urandom));
            end
            do_frame(k, "rand");
        end

        // settle on a held key, then reset in the middle of a frame
        for (int i = 0; i < 4; i++) do_frame(12'h010, "pre_rst");
        repeat (7) @(negedge clk);
        check({"pre_rst_held"}, keypad_out, select_out(12'h010));
        rst_x = 1'b0;
        #1;
        check_reset_outputs("mid_rst");
        repeat (2) @(negedge clk);
        check_reset_outputs("mid_rst_hold");
        release_and_rotate("rot2");
        for (int i = 0; i < 5; i++) do_frame(12'h010, "post_rst");
        for (int i = 0; i < 4; i++) do_frame(12'h000, "post_rel");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_scan.md
KEYPAD_SCAN -- requirements
Module: keypad_scan

Interface
- REQ-001: Parameter SCAN_DIV, default 1000, clk cycles each row is driven (1 ms at 1 MHz); legal range 4..65535.
- REQ-002: Parameter DEBOUNCE_CNT, default 4, consecutive identical frames needed before the output updates; legal range 1..15.
- REQ-003: Port clk, input, 1, sole clock; all state on its rising edge.
- REQ-004: Port rst_x, input, 1, reset, asynchronous active-low.
- REQ-005: Port col_in, input, 3, keypad column lines, active-low (pulled up), asynchronous to clk.
- REQ-006: Port row_out, output, 4, keypad row drive, active-low, exactly one bit low at any time.
- REQ-007: Port keypad_out, output, 12, debounced key map; bit r*3+c is key at row r, column c; feeds the piano keypad_in.
- REQ-008: Port key_valid, output, 1, high when keypad_out is nonzero.
- REQ-009: Port frame_done, output, 1, one-cycle pulse after row 3 is sampled.

Function
- REQ-010: col_in SHALL pass through a 2-flop synchronizer and then be inverted (pressed = 1) before sampling.
- REQ-011: A tick counter SHALL count 0..SCAN_DIV-1 while a row counter selects row r; row_out SHALL equal ~(4'b0001 << r).
- REQ-012: When the tick counter equals SCAN_DIV-1, the synchronized columns SHALL be written to raw frame bits r*3+2..r*3; the tick counter SHALL wrap to 0 and r SHALL advance, wrapping from 3 to 0.
- REQ-013: A frame SHALL be the 4*SCAN_DIV cycles covering rows 0..3; frame_done SHALL pulse in the cycle after row 3 is sampled.
- REQ-014: At frame end, if the raw frame equals the stored previous frame, stable_cnt SHALL increment and saturate at DEBOUNCE_CNT; otherwise stable_cnt SHALL clear to 0 and the previous frame SHALL be replaced.
- REQ-015: keypad_out SHALL update from the frame on the cycle after stable_cnt first reaches DEBOUNCE_CNT, and SHALL hold between updates.
- REQ-016: A changed key pattern SHALL therefore reach keypad_out after DEBOUNCE_CNT+1 identical frames; any glitch shorter than one frame SHALL NOT change keypad_out.
- REQ-017: Key release (all-zero frame) SHALL be debounced identically to a press.
- REQ-018: key_valid SHALL be the registered OR-reduction of keypad_out and change in the same cycle as keypad_out.
- REQ-019: Simultaneous sample and frame end in the same cycle SHALL include the row-3 sample in the comparison.

Reset
- REQ-020: While rst_x is low: tick counter 0, r = 0, row_out = 4'b1110, synchronizer flops 3'b111 (released), raw/previous frames 0, stable_cnt 0, keypad_out 0, key_valid 0, frame_done 0.
- REQ-021: Reset asserted mid-frame SHALL abort the frame with no output update; scanning restarts at row 0, tick 0 on the first clk edge after release.

Configuration
- REQ-022: Macro KEYPAD_MULTIKEY_EN defined: keypad_out SHALL carry the full debounced multi-hot map.
- REQ-023: Macro KEYPAD_MULTIKEY_EN undefined: keypad_out SHALL carry only the lowest-indexed set bit of the debounced map (one-hot or zero), so that the piano always receives one note.

Verification (SCAN_DIV=4, DEBOUNCE_CNT=2, frame = 16 cycles)
- REQ-024: Reset pulse with no key pressed -> row_out 1110 after reset, rotating 1101, 1011, 0111 every 4 cycles; keypad_out 0; frame_done every 16 cycles.
- REQ-025: col_in[1] low only while row 2 is driven, held steady -> keypad_out = 12'h080 (bit 7), key_valid 1, exactly 3 frames (48 cycles, +1 cycle) after the first frame containing the press.
- REQ-026: The same press held for 1 frame only, then released -> keypad_out stays 0 throughout.
- REQ-027: Keys bit 2 and bit 9 held -> keypad_out 12'h204 with KEYPAD_MULTIKEY_EN, 12'h004 without.
- REQ-028: Held key released -> keypad_out returns to 0 and key_valid to 0 after 3 release frames; rst_x pulsed low mid-frame -> all outputs return to reset values immediately and scanning restarts at row 0.
